// File: rtl/multicycle_seq_control_if.sv
// Handshake bundle between the multicycle control sequencer and the MUSA datapath.
// The master side is the sequencer: it consumes opcode/stall/resume and drives every control strobe.
interface multicycle_seq_control_if #(
    parameter int OPCODE_W = 6,
    parameter int STAGE_W  = 3,
    parameter int CNT_W    = 16,
    parameter int ALUOP_W  = 3
);
    logic [OPCODE_W-1:0] opcode;
    logic                stall;
    logic                resume;
    logic [STAGE_W-1:0]  stage;
    logic                ir_write;
    logic                pc_write;
    logic [2:0]          pcSrc;
    logic [ALUOP_W-1:0]  aluOp;
    logic [1:0]          data_a_select;
    logic [1:0]          data_b_select;
    logic                regDst;
    logic                memToReg;
    logic                memRead;
    logic                memWrite;
    logic                regWrite;
    logic                push;
    logic                pop;
    logic                aux_push_pop;
    logic                halted;
    logic                illegal;
    logic [CNT_W-1:0]    instr_retired;

    modport master (
        input  opcode, stall, resume,
        output stage, ir_write, pc_write, pcSrc, aluOp, data_a_select, data_b_select,
               regDst, memToReg, memRead, memWrite, regWrite, push, pop, aux_push_pop,
               halted, illegal, instr_retired
    );

    modport slave (
        output opcode, stall, resume,
        input  stage, ir_write, pc_write, pcSrc, aluOp, data_a_select, data_b_select,
               regDst, memToReg, memRead, memWrite, regWrite, push, pop, aux_push_pop,
               halted, illegal, instr_retired
    );
endinterface

// File: rtl/multicycle_seq_control.sv
// Variable-length multicycle control sequencer for the MUSA ID block: per-class stage
// sequences, stall/halt handling, illegal-opcode flag and a retired-instruction counter.
module multicycle_seq_control #(
    parameter int OPCODE_W = 6,
    parameter int STAGE_W  = 3,
    parameter int CNT_W    = 16,
    parameter int ALUOP_W  = 3
) (
    input logic                      clk,
    input logic                      reset,
    multicycle_seq_control_if.master bus
);

    typedef enum logic [STAGE_W-1:0] {
        S_FETCH  = STAGE_W'(0),
        S_DECODE = STAGE_W'(1),
        S_EXEC   = STAGE_W'(2),
        S_MEM    = STAGE_W'(3),
        S_WB     = STAGE_W'(4),
        S_HALTED = STAGE_W'(5)
    } stage_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'('b000000);
    localparam logic [OPCODE_W-1:0] OP_MUL   = OPCODE_W'('b011100);
    localparam logic [OPCODE_W-1:0] OP_DIV   = OPCODE_W'('b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'('b001000);
    localparam logic [OPCODE_W-1:0] OP_SUBI  = OPCODE_W'('b001001);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'('b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'('b001101);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'('b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'('b101011);
    localparam logic [OPCODE_W-1:0] OP_JR    = OPCODE_W'('b010001);
    localparam logic [OPCODE_W-1:0] OP_JPC   = OPCODE_W'('b000010);
    localparam logic [OPCODE_W-1:0] OP_BRFL  = OPCODE_W'('b000100);
    localparam logic [OPCODE_W-1:0] OP_CALL  = OPCODE_W'('b000011);
    localparam logic [OPCODE_W-1:0] OP_RET   = OPCODE_W'('b000001);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'('b111111);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'('b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'('b001);
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'('b010);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'('b011);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'('b100);
    localparam logic [ALUOP_W-1:0] ALU_BRFL  = ALUOP_W'('b101);

    stage_e              stage_q, stage_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic isAlu, isLw, isSw, isBranch, isCall, isRet, isHalt, isUndef;
    logic lastStage, advance, live, commit;
    logic [2:0]          pcSrcC;
    logic [ALUOP_W-1:0]  aluOpC;
    logic [1:0]          selAC, selBC;
    logic                regDstC, memToRegC;

    always_comb begin
        isAlu    = 1'b0;
        isLw     = 1'b0;
        isSw     = 1'b0;
        isBranch = 1'b0;
        isCall   = 1'b0;
        isRet    = 1'b0;
        isHalt   = 1'b0;
        isUndef  = 1'b0;
        case (opcode_q)
            OP_RTYPE, OP_MUL, OP_DIV,
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: isAlu = 1'b1;
            OP_LW:                   isLw = 1'b1;
            OP_SW:                   isSw = 1'b1;
            OP_JR, OP_JPC, OP_BRFL:  isBranch = 1'b1;
            OP_CALL: begin
                isBranch = 1'b1;
                isCall   = 1'b1;
            end
            OP_RET: begin
                isBranch = 1'b1;
                isRet    = 1'b1;
            end
            OP_HALT:                 isHalt = 1'b1;
            default:                 isUndef = 1'b1;
        endcase
    end

    // The stage that owns pc_write is also the one that retires the instruction.
    assign lastStage = (stage_q == S_DECODE && isHalt)
                    || (stage_q == S_EXEC && (isBranch || isUndef))
                    || (stage_q == S_MEM && isSw)
                    || (stage_q == S_WB);
    assign advance = !bus.stall;

    always_comb begin
        stage_d   = stage_q;
        opcode_d  = opcode_q;
        retired_d = retired_q;
        case (stage_q)
            S_FETCH: if (advance) begin
                opcode_d = bus.opcode;
                stage_d  = S_DECODE;
            end
            S_DECODE: if (advance) stage_d = isHalt ? S_HALTED : S_EXEC;
            S_EXEC: if (advance) begin
                if (isAlu)             stage_d = S_WB;
                else if (isLw || isSw) stage_d = S_MEM;
                else                   stage_d = S_FETCH;
            end
            S_MEM:    if (advance) stage_d = isLw ? S_WB : S_FETCH;
            S_WB:     if (advance) stage_d = S_FETCH;
            S_HALTED: if (bus.resume) stage_d = S_FETCH;
            default:  stage_d = S_FETCH;
        endcase
        if (advance && lastStage) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q   <= S_FETCH;
            opcode_q  <= '0;
            retired_q <= '0;
        end else begin
            stage_q   <= stage_d;
            opcode_q  <= opcode_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        pcSrcC    = 3'b010;
        aluOpC    = ALU_ADD;
        selAC     = 2'b00;
        selBC     = 2'b00;
        regDstC   = 1'b0;
        memToRegC = 1'b0;
        if (stage_q != S_FETCH) begin
            case (opcode_q)
                OP_RTYPE, OP_MUL, OP_DIV: begin
                    aluOpC  = ALU_RTYPE;
                    selAC   = 2'b10;
                    selBC   = 2'b01;
                    regDstC = 1'b1;
                end
                OP_ADDI: begin aluOpC = ALU_ADD; selAC = 2'b10; end
                OP_SUBI: begin aluOpC = ALU_SUB; selAC = 2'b10; end
                OP_ANDI: begin aluOpC = ALU_AND; selAC = 2'b10; end
                OP_ORI:  begin aluOpC = ALU_OR;  selAC = 2'b10; end
                OP_LW:   begin selAC = 2'b10; memToRegC = 1'b1; end
                OP_SW:   selAC = 2'b10;
                OP_BRFL: begin
                    aluOpC = ALU_BRFL;
                    selAC  = 2'b10;
                    pcSrcC = 3'b001;
                end
                OP_JR, OP_CALL: pcSrcC = 3'b001;
                OP_JPC:  begin selBC = 2'b10; pcSrcC = 3'b011; end
                OP_RET:  pcSrcC = 3'b000;
                OP_HALT: pcSrcC = 3'b100;
                default: aluOpC = ALU_RTYPE;
            endcase
        end
    end

    // Commit strobes die under stall or reset; memRead only under reset so the load stays valid.
    assign live   = !reset;
    assign commit = live && !bus.stall;

    assign bus.stage         = stage_q;
    assign bus.ir_write      = commit && stage_q == S_FETCH;
    assign bus.pc_write      = commit && lastStage;
    assign bus.memRead       = live && stage_q == S_MEM && isLw;
    assign bus.memWrite      = commit && stage_q == S_MEM && isSw;
    assign bus.regWrite      = commit && stage_q == S_WB;
    assign bus.push          = commit && stage_q == S_EXEC && isCall;
    assign bus.pop           = commit && stage_q == S_EXEC && isRet;
    assign bus.aux_push_pop  = bus.push || bus.pop;
    assign bus.halted        = stage_q == S_HALTED;
    assign bus.illegal       = live && isUndef && (stage_q == S_DECODE || stage_q == S_EXEC);
    assign bus.instr_retired = retired_q;
    assign bus.pcSrc         = pcSrcC;
    assign bus.aluOp         = aluOpC;
    assign bus.data_a_select = selAC;
    assign bus.data_b_select = selBC;
    assign bus.regDst        = regDstC;
    assign bus.memToReg      = memToRegC;

endmodule

// File: tb/tb_multicycle_seq_control.sv
// Self-checking bench for multicycle_seq_control: an instruction table drives per-cycle
// expectations into a scoreboard queue that a negedge monitor pops and compares.
module tb_multicycle_seq_control;

    localparam int OPCODE_W = 6;
    localparam int STAGE_W  = 3;
    localparam int CNT_W    = 16;
    localparam int ALUOP_W  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_seq_control_if #(
        .OPCODE_W(OPCODE_W), .STAGE_W(STAGE_W), .CNT_W(CNT_W), .ALUOP_W(ALUOP_W)
    ) bus ();

    multicycle_seq_control #(
        .OPCODE_W(OPCODE_W), .STAGE_W(STAGE_W), .CNT_W(CNT_W), .ALUOP_W(ALUOP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef enum int {K_ALU, K_LW, K_SW, K_JMP, K_CALL, K_RET, K_HALT, K_UNDEF} kind_e;

    // chkMask selects which decode fields are defined for the entry: {regDst, selB, selA, aluOp}.
    typedef struct {
        string      name;
        logic [5:0] op;
        kind_e      kind;
        logic [2:0] pcSrc;
        logic [2:0] aluOp;
        logic [1:0] selA;
        logic [1:0] selB;
        logic       regDst;
        logic [3:0] chkMask;
    } instr_t;

    typedef struct {
        string       tag;
        int          idx;
        logic [2:0]  stage;
        logic        irW, pcW, memR, memW, regW, push, pop, halted, illegal, chkDec;
        logic [15:0] retired;
    } cycExp_t;

    instr_t  tbl[16];
    cycExp_t expQ[$];
    int      checks = 0;
    int      failures = 0;
    int      tbRetired = 0;

    task automatic addEntry(input int i, input string nm, input logic [5:0] op, input kind_e k,
                            input logic [2:0] pc, input logic [2:0] alu, input logic [1:0] a,
                            input logic [1:0] b, input logic rd, input logic [3:0] m);
        tbl[i].name    = nm;
        tbl[i].op      = op;
        tbl[i].kind    = k;
        tbl[i].pcSrc   = pc;
        tbl[i].aluOp   = alu;
        tbl[i].selA    = a;
        tbl[i].selB    = b;
        tbl[i].regDst  = rd;
        tbl[i].chkMask = m;
    endtask

    function automatic int seqLen(input kind_e k);
        case (k)
            K_ALU:  return 4;
            K_LW:   return 5;
            K_SW:   return 4;
            K_HALT: return 2;
            default: return 3;
        endcase
    endfunction

    // ALU-class instructions skip MEM, so their fourth stage is WB.
    function automatic logic [2:0] seqStage(input kind_e k, input int n);
        return (k == K_ALU && n == 3) ? 3'd4 : 3'(n);
    endfunction

    function automatic cycExp_t mkExp(input int idx, input logic [2:0] s, input bit last,
                                      input bit stalled);
        cycExp_t e;
        kind_e   k;
        bit      act;
        k         = tbl[idx].kind;
        act       = !stalled;
        e.tag     = tbl[idx].name;
        e.idx     = idx;
        e.stage   = s;
        e.irW     = act && s == 3'd0;
        e.pcW     = act && last;
        e.memR    = s == 3'd3 && k == K_LW;
        e.memW    = act && s == 3'd3 && k == K_SW;
        e.regW    = act && s == 3'd4;
        e.push    = act && s == 3'd2 && k == K_CALL;
        e.pop     = act && s == 3'd2 && k == K_RET;
        e.halted  = s == 3'd5;
        e.illegal = k == K_UNDEF && (s == 3'd1 || s == 3'd2);
        e.chkDec  = s != 3'd0;
        e.retired = tbRetired[15:0];
        return e;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s %s: got %0h, expected %0h (t=%0t)", tag, what, act, expv, $time);
        end
    endtask

    task automatic checkOutput(input cycExp_t e);
        chk(e.tag, "stage",         32'(bus.stage),         32'(e.stage));
        chk(e.tag, "ir_write",      32'(bus.ir_write),      32'(e.irW));
        chk(e.tag, "pc_write",      32'(bus.pc_write),      32'(e.pcW));
        chk(e.tag, "memRead",       32'(bus.memRead),       32'(e.memR));
        chk(e.tag, "memWrite",      32'(bus.memWrite),      32'(e.memW));
        chk(e.tag, "regWrite",      32'(bus.regWrite),      32'(e.regW));
        chk(e.tag, "push",          32'(bus.push),          32'(e.push));
        chk(e.tag, "pop",           32'(bus.pop),           32'(e.pop));
        chk(e.tag, "aux_push_pop",  32'(bus.aux_push_pop),  32'(e.push | e.pop));
        chk(e.tag, "halted",        32'(bus.halted),        32'(e.halted));
        chk(e.tag, "illegal",       32'(bus.illegal),       32'(e.illegal));
        chk(e.tag, "instr_retired", 32'(bus.instr_retired), 32'(e.retired));
        if (e.chkDec) begin
            chk(e.tag, "pcSrc", 32'(bus.pcSrc), 32'(tbl[e.idx].pcSrc));
            if (tbl[e.idx].chkMask[0]) chk(e.tag, "aluOp",  32'(bus.aluOp),         32'(tbl[e.idx].aluOp));
            if (tbl[e.idx].chkMask[1]) chk(e.tag, "selA",   32'(bus.data_a_select), 32'(tbl[e.idx].selA));
            if (tbl[e.idx].chkMask[2]) chk(e.tag, "selB",   32'(bus.data_b_select), 32'(tbl[e.idx].selB));
            if (tbl[e.idx].chkMask[3]) chk(e.tag, "regDst", 32'(bus.regDst),        32'(tbl[e.idx].regDst));
        end
    endtask

    // Monitor: each cycle's expectation is popped and compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        cycExp_t e;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    task automatic applyStimulus(input logic [5:0] op, input logic st, input logic rs,
                                 input logic rst, input cycExp_t e);
        bus.opcode = op;
        bus.stall  = st;
        bus.resume = rs;
        reset      = rst;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Opcode is only valid in FETCH; afterwards its complement is driven to prove it was latched.
    task automatic runInstr(input int idx, input int stallStage, input int stallCycles,
                            input logic resumeVal);
        int         len;
        logic [2:0] s;
        logic [5:0] op;
        bit         last;
        len = seqLen(tbl[idx].kind);
        for (int n = 0; n < len; n++) begin
            s    = seqStage(tbl[idx].kind, n);
            last = (n == len - 1);
            op   = (s == 3'd0) ? tbl[idx].op : ~tbl[idx].op;
            if (int'(s) == stallStage)
                for (int j = 0; j < stallCycles; j++)
                    applyStimulus(op, 1'b1, resumeVal, 1'b0, mkExp(idx, s, last, 1'b1));
            applyStimulus(op, 1'b0, resumeVal, 1'b0, mkExp(idx, s, last, 1'b0));
            if (last) tbRetired++;
        end
    endtask

    // Stall toggles while halted and is high on the resume cycle; neither may hold the sequencer.
    task automatic runHalt(input int waitCycles);
        runInstr(15, -1, 0, 1'b0);
        for (int j = 0; j < waitCycles; j++)
            applyStimulus(~tbl[15].op, 1'(j & 1), 1'b0, 1'b0, mkExp(15, 3'd5, 1'b0, 1'b0));
        applyStimulus(~tbl[15].op, 1'b1, 1'b1, 1'b0, mkExp(15, 3'd5, 1'b0, 1'b0));
    endtask

    task automatic runResetMidLw();
        cycExp_t e;
        for (int n = 0; n < 3; n++)
            applyStimulus((n == 0) ? tbl[7].op : ~tbl[7].op, 1'b0, 1'b0, 1'b0,
                          mkExp(7, 3'(n), 1'b0, 1'b0));
        e        = mkExp(7, 3'd3, 1'b0, 1'b1);
        e.memR   = 1'b0;
        e.chkDec = 1'b0;
        e.tag    = "rstMidLw";
        applyStimulus(~tbl[7].op, 1'b0, 1'b0, 1'b1, e);
        tbRetired = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cycExp_t e;
        addEntry(0,  "R",     6'b000000, K_ALU,   3'b010, 3'b010, 2'b10, 2'b01, 1'b1, 4'b1111);
        addEntry(1,  "MUL",   6'b011100, K_ALU,   3'b010, 3'b010, 2'b10, 2'b01, 1'b1, 4'b1111);
        addEntry(2,  "DIV",   6'b000101, K_ALU,   3'b010, 3'b010, 2'b10, 2'b01, 1'b1, 4'b1111);
        addEntry(3,  "ADDI",  6'b001000, K_ALU,   3'b010, 3'b000, 2'b10, 2'b00, 1'b0, 4'b0111);
        addEntry(4,  "SUBI",  6'b001001, K_ALU,   3'b010, 3'b001, 2'b10, 2'b00, 1'b0, 4'b0111);
        addEntry(5,  "ANDI",  6'b001100, K_ALU,   3'b010, 3'b011, 2'b10, 2'b00, 1'b0, 4'b0111);
        addEntry(6,  "ORI",   6'b001101, K_ALU,   3'b010, 3'b100, 2'b10, 2'b00, 1'b0, 4'b0111);
        addEntry(7,  "LW",    6'b100011, K_LW,    3'b010, 3'b000, 2'b10, 2'b00, 1'b0, 4'b0111);
        addEntry(8,  "SW",    6'b101011, K_SW,    3'b010, 3'b000, 2'b10, 2'b00, 1'b0, 4'b0111);
        addEntry(9,  "BRFL",  6'b000100, K_JMP,   3'b001, 3'b101, 2'b10, 2'b00, 1'b0, 4'b0011);
        addEntry(10, "JR",    6'b010001, K_JMP,   3'b001, 3'b000, 2'b00, 2'b00, 1'b0, 4'b0000);
        addEntry(11, "JPC",   6'b000010, K_JMP,   3'b011, 3'b000, 2'b00, 2'b10, 1'b0, 4'b0100);
        addEntry(12, "CALL",  6'b000011, K_CALL,  3'b001, 3'b000, 2'b00, 2'b00, 1'b0, 4'b0000);
        addEntry(13, "RET",   6'b000001, K_RET,   3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 4'b0000);
        addEntry(14, "UNDEF", 6'b110000, K_UNDEF, 3'b010, 3'b010, 2'b00, 2'b00, 1'b0, 4'b0111);
        addEntry(15, "HALT",  6'b111111, K_HALT,  3'b100, 3'b000, 2'b00, 2'b00, 1'b0, 4'b0000);

        reset      = 1'b1;
        bus.opcode = '0;
        bus.stall  = 1'b0;
        bus.resume = 1'b0;
        @(posedge clk);
        #1;

        e         = mkExp(0, 3'd0, 1'b0, 1'b1);
        e.tag     = "reset";
        e.chkDec  = 1'b0;
        applyStimulus(6'b000000, 1'b0, 1'b0, 1'b1, e);

        for (int i = 0; i < 15; i++) runInstr(i, -1, 0, 1'b0);

        runInstr(7, 3, 3, 1'b0);
        runInstr(4, 0, 2, 1'b0);
        runInstr(12, 2, 2, 1'b0);
        runInstr(3, -1, 0, 1'b1);
        runHalt(10);
        runInstr(0, -1, 0, 1'b0);
        runResetMidLw();
        runInstr(3, -1, 0, 1'b0);
        runInstr(14, 1, 1, 1'b0);

        for (int w = 0; w < 5 && expQ.size() != 0; w++) @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_seq_control.md
Name: multicycle_seq_control

Overview:
Parametrised multicycle control sequencer for the MUSA core's ID block: the next generation of the fixed 5-stage control unit. Instructions are no longer held for a fixed 5 cycles. The opcode is latched at end of FETCH and decoded into a per-class stage sequence of variable length. Control strobes are gated to the stage that owns them. The block adds stall, halt/resume, illegal-opcode detection and a retired-instruction counter.

Parameters:
OPCODE_W, 6, opcode width
STAGE_W, 3, stage encoding width (must encode 0..5)
CNT_W, 16, retired-instruction counter width
ALUOP_W, 3, aluOp width

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  instruction opcode from instruction memory, valid during FETCH
stall  in  1  memory/datapath not ready; freezes sequencer
resume  in  1  leave HALTED
stage  out  STAGE_W  0=FETCH 1=DECODE 2=EXEC 3=MEM 4=WB 5=HALTED
ir_write  out  1  latch instruction register
pc_write  out  1  PC update strobe
pcSrc  out  3  PC source select
aluOp  out  ALUOP_W  ALU operation
data_a_select, data_b_select  out  2 each  ALU operand muxes
regDst, memToReg  out  1 each  writeback muxes
memRead, memWrite, regWrite  out  1 each  gated strobes
push, pop  out  1 each  return-stack strobes
aux_push_pop  out  1  stack commit pulse
halted  out  1  sequencer in HALTED
illegal  out  1  latched opcode is undefined
instr_retired  out  CNT_W  completed-instruction count

Behaviour:
- Reset (takes priority over everything):
  - stage=FETCH, opcode_q=0, instr_retired=0, illegal=0.
  - All strobes are 0 in the reset cycle. In the first cycle after reset the block is in FETCH, so ir_write=1 there.
- FETCH:
  - ir_write=1.
  - opcode_q<=opcode on exit.
  - Next state is DECODE.
- Decode uses opcode_q only. Opcode values:
  - R-type 000000, MUL 011100, DIV 000101
  - ADDI 001000, SUBI 001001, ANDI 001100, ORI 001101
  - LW 100011, SW 101011
  - JR 010001, JPC 000010, BRFL 000100, CALL 000011, RET 000001
  - HALT 111111
- Stage sequences:
  - R/MUL/DIV/imm-ALU: F,D,E,WB (MEM skipped).
  - LW: F,D,E,MEM,WB.
  - SW: F,D,E,MEM.
  - JR/JPC/BRFL/CALL/RET: F,D,E.
  - HALT: F,D,HALTED.
  - Undefined opcodes: F,D,E, with no writes and illegal=1 from DECODE through EXEC.
- Static decode values (pcSrc, aluOp, selects, regDst, memToReg) are driven combinationally from opcode_q in every stage after FETCH.
  - R/MUL/DIV: aluOp 010, a=10, b=01, regDst=1.
  - ADDI 000, SUBI 001, ANDI 011, ORI 100: a=10, b=00.
  - LW/SW: aluOp 000, a=10, b=00.
  - BRFL: aluOp 101, a=10.
  - JPC: b=10.
  - pcSrc: sequential=010, JR/BRFL/CALL=001, JPC=011, RET=000, HALT=100.
  - Undefined opcodes: aluOp 010, selects 00.
- Strobe gating:
  - memRead is high in MEM (LW) and held through stalls.
  - memWrite: MEM (SW).
  - regWrite: WB.
  - push: EXEC (CALL).
  - pop: EXEC (RET).
  - aux_push_pop=push|pop.
  - pc_write is high in the last stage of the sequence; for HALT, in DECODE with pcSrc=100.
- Stall=1:
  - stage and opcode_q hold.
  - ir_write, pc_write, memWrite, regWrite, push, pop and aux_push_pop are forced 0.
  - memRead and static decode values are held.
  - Commit happens on the first cycle with stall=0.
  - stall is ignored in HALTED.
- Retire: in the last stage with stall=0, instr_retired increments (wraps at 2^CNT_W) and the next state is FETCH.
  - HALT retires on entering HALTED.
- HALTED:
  - halted=1 and all strobes are 0.
  - resume=1 moves to FETCH next cycle; resume is ignored in all other states.
- Simultaneous reset and any other input: reset wins.
- reset mid-instruction abandons it without commit.

Test Plan:
- Reset, then ADDI with stall=0 -> stages 0,1,2,4; regWrite=1 only in stage 4 cycle; pc_write=1 same cycle; instr_retired=1 after 4 cycles.
- LW with stall=1 for 3 cycles in MEM -> stage holds 3; memRead=1 for 4 cycles; regWrite only in WB; 5+3=8 cycles to FETCH.
- SW followed by BRFL -> memWrite=1 exactly one cycle in MEM; BRFL pc_write in EXEC with pcSrc=001, aluOp=101; instr_retired=2.
- CALL, then RET -> push=1, aux_push_pop=1 in CALL EXEC; pop=1 in RET EXEC with pcSrc=000; no regWrite.
- HALT, hold resume=0 for 10 cycles, then resume=1 -> halted=1, stage=5, all strobes 0 throughout; FETCH next cycle; instr_retired incremented once.
- Opcode 110000, plus reset asserted mid-LW in MEM -> illegal=1 in DECODE/EXEC, no writes, retires in 3 cycles; reset returns stage=0, instr_retired=0, no memRead the following cycle.
